aes_ctr_stream_engine: RTL and testbench

- Parametrised successor to the AES-256 co-processor datapath. Turns a word stream into CTR-mode ciphertext or plaintext: assembles words into blocks and requests one keystream block per data block from an external AES core.
- Requests go over a valid/ready interface with in-order, arbitrary-latency return. The engine XORs each keystream block with its data block and disassembles the result back into words.
- Counter advances only per issued block, and partial final blocks are supported. Sits between the coprocessor register file (or a DMA port) and the aes_256 core.

---
 rtl/aes_ctr_stream_engine_pkg.sv | 17 +
 rtl/aes_ctr_stream_engine_if.sv | 28 ++
 rtl/aes_ctr_stream_engine_pending.sv | 78 +++++++
 rtl/aes_ctr_stream_engine.sv | 133 +++++++++++++
 tb/tb_aes_ctr_stream_engine.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_ctr_stream_engine_pkg.sv
// Shared definitions for the CTR stream engine: default widths, the assembler
// state encoding and a ceil-log2 helper for sizing indices and pointers.
package aes_stream_pkg;
   localparam int WSIZE_DEF = 32;
   localparam int BSIZE_DEF = 128;
   localparam int NW_DEF    = BSIZE_DEF / WSIZE_DEF;

   typedef enum logic {FILL = 1'b0, ISSUE = 1'b1} asm_state_e;

   function automatic int log2c(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/aes_ctr_stream_engine_if.sv
// Word stream in/out plus keystream request/response channel of the engine.
interface aes_ctr_stream_engine_if #(
   parameter int WSIZE = 32,
   parameter int BSIZE = 128
);
   logic [WSIZE-1:0] in_word;
   logic             in_valid;
   logic             in_ready;
   logic             in_last;
   logic [WSIZE-1:0] out_word;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic [BSIZE-1:0] ks_ctr;
   logic             ks_req_valid;
   logic             ks_req_ready;
   logic [BSIZE-1:0] ks_data;
   logic             ks_valid;

   modport master (
      output in_word, in_valid, in_last, out_ready, ks_req_ready, ks_data, ks_valid,
      input  in_ready, out_word, out_valid, out_last, ks_ctr, ks_req_valid
   );
   modport slave (
      input  in_word, in_valid, in_last, out_ready, ks_req_ready, ks_data, ks_valid,
      output in_ready, out_word, out_valid, out_last, ks_ctr, ks_req_valid
   );
endinterface

// File: rtl/aes_ctr_stream_engine_pending.sv
// Pending block queue: entries are allocated at request time, filled with keystream
// in request order, and popped once fully emitted.
module ctr_pending_queue
   import aes_stream_pkg::*;
#(
   parameter int BSIZE  = 128,
   parameter int NWW    = 3,
   parameter int PDEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [BSIZE-1:0] push_pt,
   input  logic [NWW-1:0]   push_nwords,
   input  logic             push_last,
   input  logic             ks_valid,
   input  logic [BSIZE-1:0] ks_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic             head_ready,
   output logic [BSIZE-1:0] head_pt,
   output logic [BSIZE-1:0] head_ks,
   output logic [NWW-1:0]   head_nwords,
   output logic             head_last
);
   localparam int PW = log2c(PDEPTH);

   logic [PW-1:0]     wptr, kptr, rptr;
   logic [PW:0]       count, ocnt;
   logic [PDEPTH-1:0] ksok, last_mem;
   logic [BSIZE-1:0]  pt_mem [PDEPTH];
   logic [BSIZE-1:0]  ks_mem [PDEPTH];
   logic [NWW-1:0]    nw_mem [PDEPTH];
   logic              fill;

   // responses with nothing outstanding (e.g. stale ones after reset) are dropped
   assign fill        = ks_valid & (ocnt != '0);
   assign full        = (count == (PW+1)'(PDEPTH));
   assign empty       = (count == '0);
   assign head_ready  = ~empty & ksok[rptr];
   assign head_pt     = pt_mem[rptr];
   assign head_ks     = ks_mem[rptr];
   assign head_nwords = nw_mem[rptr];
   assign head_last   = last_mem[rptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr  <= '0;
         kptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ocnt  <= '0;
         ksok  <= '0;
      end else begin
         if (push) begin
            wptr       <= wptr + PW'(1);
            ksok[wptr] <= 1'b0;
         end
         if (fill) begin
            kptr       <= kptr + PW'(1);
            ksok[kptr] <= 1'b1;
         end
         if (pop) rptr <= rptr + PW'(1);
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
         ocnt  <= ocnt + (PW+1)'(push) - (PW+1)'(fill);
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         pt_mem[wptr]   <= push_pt;
         nw_mem[wptr]   <= push_nwords;
         last_mem[wptr] <= push_last;
      end
      if (fill) ks_mem[kptr] <= ks_data;
   end
endmodule

// File: rtl/aes_ctr_stream_engine.sv
// CTR-mode stream engine: packs words into blocks, requests one keystream block per
// data block, XORs the returned keystream and unpacks the result back into words.
module aes_ctr_stream_engine
   import aes_stream_pkg::*;
#(
   parameter int WSIZE  = WSIZE_DEF,
   parameter int BSIZE  = BSIZE_DEF,
   parameter int CTRW   = 32,
   parameter int PDEPTH = 4,
   parameter int CNTW   = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   ctr_load,
   input  logic [BSIZE-1:0]       ctr_init,
   output logic                   busy,
   aes_ctr_stream_engine_if.slave bus,
   output logic [CNTW-1:0]        blk_count,
   input  logic [CNTW-1:0]        irq_thresh,
   input  logic                   irq_clear,
   output logic                   irq,
   output logic                   ctr_wrap
);
   localparam int NW   = BSIZE / WSIZE;
   localparam int IDXW = (NW > 1) ? log2c(NW) : 1;
   localparam int NWW  = log2c(NW + 1);

   asm_state_e               state, state_nxt;
   logic [IDXW-1:0]          idx, oidx;
   logic [NW-1:0][WSIZE-1:0] abuf, xblk;
   logic [NWW-1:0]           anw, head_nwords;
   logic                     alast, head_last;
   logic [BSIZE-1:0]         ctr, head_pt, head_ks;
   logic [CNTW-1:0]          blk_nxt;
   logic in_hs, blk_end, req_hs, q_full, q_empty, head_ready;
   logic out_hs, oend, pop, thr_hit, irq_set;

   assign bus.in_ready     = (state == FILL) & enable;
   assign bus.ks_req_valid = (state == ISSUE) & enable & ~q_full;
   assign bus.ks_ctr       = ctr;
   assign in_hs   = bus.in_valid & bus.in_ready;
   assign blk_end = in_hs & (bus.in_last | (idx == IDXW'(NW - 1)));
   assign req_hs  = bus.ks_req_valid & bus.ks_req_ready;
   assign busy    = (state == ISSUE) | (idx != '0) | ~q_empty;

   always_ff @(posedge clock) begin
      if (reset) state <= FILL;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (blk_end) state_nxt = ISSUE;
         ISSUE:   if (req_hs)  state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   // buffer is zeroed when a block leaves so short final blocks pad with zeros
   always_ff @(posedge clock) begin
      if (reset) begin
         idx      <= '0;
         abuf     <= '0;
         anw      <= '0;
         alast    <= 1'b0;
         ctr      <= '0;
         ctr_wrap <= 1'b0;
      end else begin
         if (in_hs) begin
            abuf[idx] <= bus.in_word;
            if (blk_end) begin
               anw   <= NWW'(idx) + NWW'(1);
               alast <= bus.in_last;
            end else begin
               idx <= idx + IDXW'(1);
            end
         end
         if (req_hs) begin
            idx             <= '0;
            abuf            <= '0;
            ctr[CTRW-1:0]   <= ctr[CTRW-1:0] + CTRW'(1);
            if (&ctr[CTRW-1:0]) ctr_wrap <= 1'b1;
         end else if (ctr_load & ~busy) begin
            ctr <= ctr_init;
         end
      end
   end

   ctr_pending_queue #(.BSIZE(BSIZE), .NWW(NWW), .PDEPTH(PDEPTH)) u_pq (
      .clock       (clock),
      .reset       (reset),
      .push        (req_hs),
      .push_pt     (abuf),
      .push_nwords (anw),
      .push_last   (alast),
      .ks_valid    (bus.ks_valid),
      .ks_data     (bus.ks_data),
      .pop         (pop),
      .full        (q_full),
      .empty       (q_empty),
      .head_ready  (head_ready),
      .head_pt     (head_pt),
      .head_ks     (head_ks),
      .head_nwords (head_nwords),
      .head_last   (head_last)
   );

   assign xblk          = head_pt ^ head_ks;
   assign oend          = (NWW'(oidx) == head_nwords - NWW'(1));
   assign bus.out_valid = head_ready;
   assign bus.out_word  = head_ready ? xblk[oidx] : '0;
   assign bus.out_last  = head_ready & head_last & oend;
   assign out_hs        = head_ready & bus.out_ready;
   assign pop           = out_hs & oend;
   assign blk_nxt       = blk_count + CNTW'(1);
   assign thr_hit       = pop & (irq_thresh != '0) & (blk_nxt == irq_thresh);
   assign irq_set       = (out_hs & bus.out_last) | thr_hit;

   always_ff @(posedge clock) begin
      if (reset) begin
         oidx      <= '0;
         blk_count <= '0;
         irq       <= 1'b0;
      end else begin
         if (out_hs) oidx <= oend ? '0 : oidx + IDXW'(1);
         if (pop) blk_count <= blk_nxt;
         if (irq_set)        irq <= 1'b1;
         else if (irq_clear) irq <= 1'b0;
      end
   end
endmodule

// File: tb/tb_aes_ctr_stream_engine.sv
// Directed bench for aes_ctr_stream_engine with a latency-programmable keystream responder.
module tb_aes_ctr_stream_engine;
   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         enable = 1'b0;
   logic         ctr_load = 1'b0;
   logic         irq_clear = 1'b0;
   logic [127:0] ctr_init = '0;
   logic         busy, irq, ctr_wrap;
   logic [15:0]  blk_count;
   logic [15:0]  irq_thresh = '0;

   aes_ctr_stream_engine_if #(.WSIZE(32), .BSIZE(128)) bus ();

   aes_ctr_stream_engine #(.WSIZE(32), .BSIZE(128), .CTRW(32), .PDEPTH(4), .CNTW(16)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .ctr_load   (ctr_load),
      .ctr_init   (ctr_init),
      .busy       (busy),
      .bus        (bus),
      .blk_count  (blk_count),
      .irq_thresh (irq_thresh),
      .irq_clear  (irq_clear),
      .irq        (irq),
      .ctr_wrap   (ctr_wrap)
   );

   always #5 clock = ~clock;

   int           n_chk = 0, n_fail = 0, ncyc = 0, lat = 1, irq_hi = 0, ks_cyc = 0;
   logic         ks_use_ctr = 1'b0;
   logic [127:0] ks_fixed = '1;
   logic [15:0]  irq_blk = '0;
   logic [127:0] req_ctr[$];
   logic [127:0] ks_q[$];
   int           ks_due[$];
   logic [31:0]  got_w[$];
   logic         got_l[$];
   int           got_c[$];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // responder + monitor, sampling well after the falling edge
   initial forever begin
      @(negedge clock);
      #2;
      ncyc++;
      bus.ks_valid = 1'b0;
      if (ks_due.size() > 0 && ks_due[0] <= ncyc) begin
         bus.ks_valid = 1'b1;
         bus.ks_data  = ks_use_ctr ? {4{ks_q[0][31:0]}} : ks_fixed;
         void'(ks_q.pop_front());
         void'(ks_due.pop_front());
         ks_cyc = ncyc;
      end
      if (!reset && bus.ks_req_valid && bus.ks_req_ready) begin
         req_ctr.push_back(bus.ks_ctr);
         ks_q.push_back(bus.ks_ctr);
         ks_due.push_back(ncyc + lat);
      end
      if (!reset && bus.out_valid && bus.out_ready) begin
         got_w.push_back(bus.out_word);
         got_l.push_back(bus.out_last);
         got_c.push_back(ncyc);
      end
      if (!reset && irq) begin
         irq_hi++;
         irq_blk = blk_count;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic send(input logic [31:0] w, input logic l);
      int t;
      t = 0;
      bus.in_word = w; bus.in_last = l; bus.in_valid = 1'b1;
      while (!bus.in_ready && t < 200) begin
         @(negedge clock);
         t++;
      end
      if (t >= 200) chk("send_timeout", 128'(bus.in_ready), 128'(1));
      @(negedge clock);
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
   endtask

   task automatic wait_out(input int n, input int budget);
      int t;
      t = 0;
      while (got_w.size() < n && t < budget) begin
         @(negedge clock);
         t++;
      end
      chk("out_count", 128'(got_w.size()), 128'(n));
   endtask

   task automatic clr();
      got_w.delete(); got_l.delete(); got_c.delete(); req_ctr.delete();
   endtask

   task automatic load(input logic [127:0] v);
      ctr_init = v; ctr_load = 1'b1;
      @(negedge clock);
      ctr_load = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      logic [5:0] lv;
      bus.in_word = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
      bus.out_ready = 1'b1; bus.ks_req_ready = 1'b1; bus.ks_data = '0; bus.ks_valid = 1'b0;

      // reset state
      repeat (3) @(negedge clock);
      chk("reset_flags", 128'({bus.in_ready, bus.out_valid, bus.out_last, bus.ks_req_valid,
                                busy, irq, ctr_wrap}), 128'(0));
      chk("reset_ctr", bus.ks_ctr, 128'(0));
      chk("reset_cnt_word", 128'({blk_count, bus.out_word}), 128'(0));
      reset = 1'b0; enable = 1'b1;
      @(negedge clock);
      chk("idle_in_ready", 128'(bus.in_ready), 128'(1));

      // full block, ks all-ones one cycle after the request
      load(128'hFF);
      chk("t1_ctr_loaded", bus.ks_ctr, 128'hFF);
      clr(); lat = 1; ks_use_ctr = 1'b0;
      for (int i = 1; i <= 4; i++) send(32'(i), 1'b0);
      wait_out(4, 50);
      if (got_w.size() == 4) begin
         chk("t1_words", {got_w[3], got_w[2], got_w[1], got_w[0]},
             128'hFFFFFFFB_FFFFFFFC_FFFFFFFD_FFFFFFFE);
         chk("t1_ks_to_out", 128'(got_c[0]), 128'(ks_cyc + 1));
      end
      chk("t1_nreq", 128'(req_ctr.size()), 128'(1));
      if (req_ctr.size() == 1) chk("t1_req_ctr", req_ctr[0], 128'hFF);
      repeat (2) @(negedge clock);
      chk("t1_ctr_next", bus.ks_ctr, 128'h100);
      chk("t1_blk_irq_busy", 128'({blk_count, irq, busy}), 128'({16'd1, 1'b0, 1'b0}));

      // partial final block: 6 words, last on the 6th
      clr(); lat = 3; ks_use_ctr = 1'b1;
      for (int i = 0; i < 6; i++) send(32'h10 + 32'(i), i == 5);
      wait_out(6, 80);
      repeat (3) @(negedge clock);
      chk("t2_count_final", 128'(got_w.size()), 128'(6));
      chk("t2_nreq", 128'(req_ctr.size()), 128'(2));
      if (got_w.size() == 6) begin
         chk("t2_words", 128'({got_w[5], got_w[4], got_w[3], got_w[2], got_w[1], got_w[0]}),
             128'({32'h114, 32'h115, 32'h113, 32'h112, 32'h111, 32'h110}));
         for (int k = 0; k < 6; k++) lv[k] = got_l[k];
         chk("t2_last", 128'(lv), 128'(6'b100000));
      end
      chk("t2_irq", 128'(irq), 128'(1));
      chk("t2_blk", 128'(blk_count), 128'(3));
      irq_clear = 1'b1;
      @(negedge clock);
      irq_clear = 1'b0;
      chk("t2_irq_cleared", 128'(irq), 128'(0));

      // low counter word wraps, upper bits untouched
      load(128'h01234567_89ABCDEF_DEADBEEF_FFFFFFFF);
      chk("t3_wrap_before", 128'(ctr_wrap), 128'(0));
      clr();
      send(32'h11111111, 1'b0); send(32'h22222222, 1'b0);
      send(32'h33333333, 1'b0); send(32'h44444444, 1'b0);
      wait_out(4, 50);
      repeat (2) @(negedge clock);
      chk("t3_ctr", bus.ks_ctr, 128'h01234567_89ABCDEF_DEADBEEF_00000000);
      chk("t3_wrap", 128'(ctr_wrap), 128'(1));
      if (got_w.size() == 4)
         chk("t3_words", {got_w[3], got_w[2], got_w[1], got_w[0]},
             128'hBBBBBBBB_CCCCCCCC_DDDDDDDD_EEEEEEEE);

      // backpressure: long latency, output stalled, 8 blocks
      load(128'h1000);
      clr(); lat = 14; bus.out_ready = 1'b0;
      fork
         begin
            for (int b = 0; b < 8; b++)
               for (int i = 0; i < 4; i++)
                  send(32'h100 + 32'(b * 4 + i), (b == 7) && (i == 3));
         end
         begin
            repeat (30) @(negedge clock);
            load(128'hDEAD);
            repeat (30) @(negedge clock);
            chk("t4_outstanding", 128'(req_ctr.size()), 128'(4));
            chk("t4_req_stalled", 128'(bus.ks_req_valid), 128'(0));
            chk("t4_no_out", 128'(got_w.size()), 128'(0));
            bus.out_ready = 1'b1;
         end
      join
      wait_out(32, 400);
      if (got_w.size() == 32) begin
         for (int k = 0; k < 32; k++)
            chk("t4_word", 128'(got_w[k]), 128'((32'h100 + 32'(k)) ^ (32'h1000 + 32'(k / 4))));
         chk("t4_no_bubble", 128'(got_c[15] - got_c[0]), 128'(15));
         chk("t4_last_pos", 128'({got_l[31], got_l[30], got_l[3]}), 128'(3'b100));
      end
      chk("t4_nreq", 128'(req_ctr.size()), 128'(8));
      if (req_ctr.size() == 8) chk("t4_req_ctr7", req_ctr[7], 128'h1007);
      repeat (2) @(negedge clock);
      chk("t4_blk_irq", 128'({blk_count, irq}), 128'({16'd12, 1'b1}));

      // threshold irq with clear held high
      do_reset();
      chk("t5_reset", 128'({blk_count, irq, ctr_wrap, busy}), 128'(0));
      chk("t5_reset_ctr", bus.ks_ctr, 128'(0));
      clr(); lat = 2; irq_thresh = 16'd3; irq_clear = 1'b1; irq_hi = 0;
      for (int b = 0; b < 3; b++)
         for (int i = 0; i < 4; i++) send(32'(b * 4 + i), 1'b0);
      wait_out(12, 200);
      repeat (4) @(negedge clock);
      chk("t5_irq_pulses", 128'(irq_hi), 128'(1));
      chk("t5_irq_at_blk", 128'(irq_blk), 128'(3));
      for (int i = 0; i < 4; i++) send(32'(i), 1'b0);
      wait_out(16, 100);
      repeat (4) @(negedge clock);
      chk("t5_no_reirq", 128'({irq_hi[7:0], blk_count}), 128'({8'd1, 16'd4}));
      irq_clear = 1'b0; irq_thresh = '0;

      // reset mid-message with one request outstanding
      clr(); lat = 10;
      for (int i = 0; i < 6; i++) send(32'hA0 + 32'(i), 1'b0);
      chk("t6_nreq", 128'(req_ctr.size()), 128'(1));
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("t6_after_reset", 128'({busy, bus.out_valid, bus.ks_req_valid, irq, blk_count}), 128'(0));
      chk("t6_ctr_zero", bus.ks_ctr, 128'(0));
      repeat (20) @(negedge clock);
      chk("t6_late_ks_dropped", 128'({got_w.size(), busy}), 128'(0));
      load(128'h5);
      lat = 2;
      send(32'h10, 1'b0); send(32'h20, 1'b0); send(32'h30, 1'b0); send(32'h40, 1'b1);
      wait_out(4, 60);
      if (got_w.size() == 4) begin
         chk("t6_words", {got_w[3], got_w[2], got_w[1], got_w[0]},
             128'h00000045_00000035_00000025_00000015);
         chk("t6_last", 128'({got_l[3], got_l[2], got_l[1], got_l[0]}), 128'(4'b1000));
      end
      repeat (2) @(negedge clock);
      chk("t6_blk_irq", 128'({blk_count, irq}), 128'({16'd1, 1'b1}));

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
